// File: rtl/spi_master_driver_pkg.sv
// Shared SPI definitions: bus mode, slave-select level helper and the
// control FSM state encoding used by the master and slave drivers.
package spi_master_driver_pkg;

  typedef enum logic [1:0] {
    SPI_MODE_0,
    SPI_MODE_1,
    SPI_MODE_2,
    SPI_MODE_3
  } spiMode_e;

  localparam spiMode_e SPI_MODE = SPI_MODE_0;

  typedef logic [2:0] spiState_t;

  localparam spiState_t ST_IDLE  = 3'd0;
  localparam spiState_t ST_LEAD  = 3'd1;
  localparam spiState_t ST_HIGH  = 3'd2;
  localparam spiState_t ST_LOW   = 3'd3;
  localparam spiState_t ST_TRAIL = 3'd4;
  localparam spiState_t ST_GUARD = 3'd5;

  // Electrical SS level for an asserted/deasserted select.
  function automatic logic ssLevel(input logic activeLow, input logic asserted);
    return asserted ^ activeLow;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parameterised load / serial-in / serial-out shift register shared by the
// TX and RX paths; LSB_FIRST selects the shift direction.
module spi_shift_reg
  import spi_master_driver_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadData,
  input  logic             i_shift,
  input  logic             i_serialIn,
  output logic [WIDTH-1:0] o_data,
  output logic             o_serialOut
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_loadData;
    end else if (i_shift) begin
      r_data <= LSB_FIRST ? {i_serialIn, r_data[WIDTH-1:1]}
                          : {r_data[WIDTH-2:0], i_serialIn};
    end
  end

  assign o_data      = r_data;
  assign o_serialOut = LSB_FIRST ? r_data[0] : r_data[WIDTH-1];

endmodule

// File: rtl/spi_master_driver.sv
// SPI mode-0 master: serialises one word on MOSI and captures one from MISO
// per transfer, generating SS and SCLK from sys_clk with a ready/new-data handshake.
module spi_master_driver
  import spi_master_driver_pkg::*;
#(
  parameter bit SS_ACTIVE_LOW    = 1'b1,
  parameter bit LSB_FIRST        = 1'b0,
  parameter int NUM_DATA_BITS    = 16,
  parameter int SCLK_HALF_PERIOD = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     comm_start,
  input  logic                     comm_abort,
  input  logic                     mosi_send_enable,
  input  logic [NUM_DATA_BITS-1:0] mosi_data,
  output logic                     bus_ready,
  output logic                     miso_new_data,
  output logic [NUM_DATA_BITS-1:0] miso_data,
  output logic                     ss_out,
  output logic                     sclk_out,
  output logic                     mosi_out,
  input  logic                     miso_in
);

  localparam int PW = $clog2(SCLK_HALF_PERIOD);
  localparam int BW = $clog2(NUM_DATA_BITS);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_DATA_BITS - 1);
  localparam logic SS_ON     = ssLevel(SS_ACTIVE_LOW, 1'b1);
  localparam logic SS_OFF    = ssLevel(SS_ACTIVE_LOW, 1'b0);
  localparam logic SCLK_IDLE = (SPI_MODE == SPI_MODE_2) || (SPI_MODE == SPI_MODE_3);

  spiState_t          r_state;
  logic [PW-1:0]      r_phase;
  logic [BW-1:0]      r_bitCnt;
  logic               r_busReady;
  logic               r_newData;
  logic [NUM_DATA_BITS-1:0] r_misoData;
  logic               r_ss;
  logic               r_sclk;

  logic               w_phaseEnd;
  logic               w_lastBit;
  logic               w_inTransfer;
  logic               w_abort;
  logic               w_accept;
  logic               w_highEnd;
  logic               w_txLoad;
  logic               w_txShift;
  logic [NUM_DATA_BITS-1:0] w_txLoadData;
  logic [NUM_DATA_BITS-1:0] w_txData;
  logic               w_txSerial;
  logic [NUM_DATA_BITS-1:0] w_rxData;
  logic               w_rxSerial;
  logic               w_unusedBits;

  assign w_phaseEnd   = (r_phase == PHASE_LAST);
  assign w_lastBit    = (r_bitCnt == BIT_LAST);
  assign w_inTransfer = (r_state == ST_LEAD) || (r_state == ST_HIGH) ||
                        (r_state == ST_LOW)  || (r_state == ST_TRAIL);
  assign w_abort      = comm_abort && w_inTransfer;
  assign w_accept     = (r_state == ST_IDLE) && comm_start && !comm_abort;
  assign w_highEnd    = (r_state == ST_HIGH) && w_phaseEnd && !comm_abort;

  // Loading zeros on the last sample or an abort parks MOSI low without a separate flop.
  assign w_txLoad     = w_accept || w_abort || (w_highEnd && w_lastBit);
  assign w_txShift    = w_highEnd && !w_lastBit;
  assign w_txLoadData = (w_accept && mosi_send_enable) ? mosi_data : '0;

  spi_shift_reg #(
    .WIDTH     (NUM_DATA_BITS),
    .LSB_FIRST (LSB_FIRST)
  ) u_txReg (
    .clk         (sys_clk),
    .rst_n       (rst),
    .i_load      (w_txLoad),
    .i_loadData  (w_txLoadData),
    .i_shift     (w_txShift),
    .i_serialIn  (1'b0),
    .o_data      (w_txData),
    .o_serialOut (w_txSerial)
  );

  spi_shift_reg #(
    .WIDTH     (NUM_DATA_BITS),
    .LSB_FIRST (LSB_FIRST)
  ) u_rxReg (
    .clk         (sys_clk),
    .rst_n       (rst),
    .i_load      (w_accept),
    .i_loadData  ('0),
    .i_shift     (w_highEnd),
    .i_serialIn  (miso_in),
    .o_data      (w_rxData),
    .o_serialOut (w_rxSerial)
  );

  assign w_unusedBits = ^{w_txData, w_rxSerial};

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_GUARD;
      r_phase    <= '0;
      r_bitCnt   <= '0;
      r_busReady <= 1'b0;
      r_newData  <= 1'b0;
      r_misoData <= '0;
      r_ss       <= SS_OFF;
      r_sclk     <= SCLK_IDLE;
    end else begin
      r_newData <= 1'b0;
      if (w_abort) begin
        r_state <= ST_GUARD;
        r_phase <= '0;
        r_ss    <= SS_OFF;
        r_sclk  <= SCLK_IDLE;
      end else if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_state    <= ST_LEAD;
          r_phase    <= '0;
          r_bitCnt   <= '0;
          r_busReady <= 1'b0;
          r_ss       <= SS_ON;
        end
      end else begin
        r_phase <= w_phaseEnd ? '0 : r_phase + 1'b1;
        if (w_phaseEnd) begin
          case (r_state)
            ST_LEAD: begin
              r_state <= ST_HIGH;
              r_sclk  <= ~SCLK_IDLE;
            end
            ST_HIGH: begin
              r_sclk <= SCLK_IDLE;
              if (w_lastBit) begin
                r_state <= ST_TRAIL;
              end else begin
                r_state  <= ST_LOW;
                r_bitCnt <= r_bitCnt + 1'b1;
              end
            end
            ST_LOW: begin
              r_state <= ST_HIGH;
              r_sclk  <= ~SCLK_IDLE;
            end
            ST_TRAIL: begin
              r_state    <= ST_GUARD;
              r_ss       <= SS_OFF;
              r_misoData <= w_rxData;
              r_newData  <= 1'b1;
            end
            ST_GUARD: begin
              r_state    <= ST_IDLE;
              r_busReady <= 1'b1;
            end
            default: r_state <= ST_GUARD;
          endcase
        end
      end
    end
  end

  assign bus_ready     = r_busReady;
  assign miso_new_data = r_newData;
  assign miso_data     = r_misoData;
  assign ss_out        = r_ss;
  assign sclk_out      = r_sclk;
  assign mosi_out      = w_txSerial;

endmodule

// File: doc/spi_master_driver.md
Name: spi_master_driver

Overview:
- SPI master (mode 0: SCLK idles low, data sampled on the rising edge, data changed on the falling edge). It is the initiating end for the team's SPI slave driver.
- Serialises one NUM_DATA_BITS word onto MOSI and captures one word from MISO per transfer. It generates SS and SCLK from sys_clk.
- It sits on the MITM bus side facing a real SPI slave. The control FSM uses the same ready / new-data handshake style as the slave driver.

Parameters:
- SS_ACTIVE_LOW, 1: 1 means SS is asserted low; 0 means asserted high.
- LSB_FIRST, 0: 1 means bit 0 is shifted first on both lines; 0 means MSB first.
- NUM_DATA_BITS, 16: word width, valid range >= 2.
- SCLK_HALF_PERIOD, 8: sys_clk cycles per SCLK half period (H). Valid range >= 4, so the slave's input synchronisers have margin.

Ports:
- sys_clk  in  1  system clock. All logic is on its rising edge.
- rst  in  1  Reset is asynchronous and active-low.
- comm_start  in  1  start request. Accepted only while bus_ready=1.
- comm_abort  in  1  terminates a transfer in progress.
- mosi_send_enable  in  1  sampled with comm_start. 0 means MOSI stays 0 for the whole transfer.
- mosi_data  in  NUM_DATA_BITS  word to send. Latched on accept.
- bus_ready  out  1  idle; a new comm_start will be accepted.
- miso_new_data  out  1  one-cycle pulse when miso_data is updated.
- miso_data  out  NUM_DATA_BITS  last received word. Held until the next completed transfer.
- ss_out  out  1  slave select.
- sclk_out  out  1  serial clock.
- mosi_out  out  1  master out.
- miso_in  in  1  master in. Driven by the slave synchronously to sclk_out, so no synchroniser is needed.

Behaviour:
- Reset (rst=0, asynchronous):
  - bus_ready=0, miso_new_data=0, miso_data=0.
  - ss_out inactive, sclk_out=0, mosi_out=0.
  - FSM=GUARD with its counter cleared, so bus_ready rises H cycles after rst releases.
- All outputs are registered.
- One phase counter counts 0..H-1. Every state except IDLE lasts exactly H cycles.
- One bit counter counts 0..NUM_DATA_BITS-1.
- FSM states:
  - IDLE: bus_ready=1. On comm_start:
    - latch mosi_data into the TX shift register (all zeros if mosi_send_enable=0);
    - clear the RX shift register;
    - next cycle: bus_ready=0, ss_out active, mosi_out=first bit; go to LEAD.
  - LEAD: SS active, SCLK low, first bit driven. After H cycles go to HIGH.
  - HIGH: sclk_out=1.
    - On the last cycle of the phase, shift miso_in into the RX register.
    - After H cycles: sclk_out=0. If the last bit has been sampled go to TRAIL; otherwise drive the next bit on mosi_out and go to LOW.
  - LOW: sclk_out=0, current bit stable on mosi_out. After H cycles go to HIGH.
  - TRAIL: SCLK low, mosi_out=0. After H cycles:
    - ss_out inactive;
    - miso_data <= RX register;
    - miso_new_data=1 for exactly one cycle;
    - go to GUARD.
  - GUARD: SS inactive. After H cycles go to IDLE.
- Timing per transfer:
  - SS is active for H*(2*NUM_DATA_BITS+1) cycles (H=8, N=16: 264).
  - accept to bus_ready high is H*(2*NUM_DATA_BITS+2)+1 cycles.
- Bit order:
  - LSB_FIRST=0: the TX register shifts left and outputs bit N-1; RX shifts in at bit 0.
  - LSB_FIRST=1: mirrored.
- comm_start while bus_ready=0 is ignored. Requests are not queued.
- comm_start and comm_abort asserted together in IDLE: the abort wins and the start is ignored.
- comm_abort in LEAD, HIGH, LOW or TRAIL:
  - next cycle: ss_out inactive, sclk_out=0, mosi_out=0;
  - go to GUARD;
  - no miso_new_data pulse; miso_data is unchanged.
- comm_abort in IDLE or GUARD has no effect.
- mosi_data may change after the accept cycle without affecting the transfer.

Decomposition:
- Shared SPI package:
  - SPI mode constant;
  - SS level helper: active/inactive level from SS_ACTIVE_LOW;
  - FSM state enum: IDLE, LEAD, HIGH, LOW, TRAIL, GUARD.
- One natural sub-module: spi_shift_reg, a parameterised shift register with load and serial-in/serial-out. The TX and RX paths share it with LSB_FIRST selecting the direction. The slave driver can reuse it.

Test Plan:
1. H=8, N=16, MSB first. Start with mosi_data=16'h4ac5, send enable on; slave model returns 16'h0cf7.
   - Bits captured at the 16 sclk_out rising edges equal 4ac5.
   - miso_data=16'h0cf7 with a single miso_new_data pulse.
   - ss_out low for exactly 264 cycles; bus_ready high 8 cycles after SS deasserts.
2. LSB_FIRST=1, mosi_data=16'h16fb, slave returns 16'h37e1.
   - MOSI bit sequence is 1,1,0,1,1,1,1,1,0,1,1,0,1,0,0,0.
   - miso_data=16'h37e1.
3. mosi_send_enable=0, mosi_data=16'h35d9, slave returns 16'h2fa0.
   - mosi_out=0 throughout.
   - miso_data=16'h2fa0.
4. Assert comm_abort in the HIGH phase of the 6th bit.
   - SS inactive and SCLK low on the next cycle.
   - No miso_new_data; miso_data keeps its previous value (16'h2fa0).
   - bus_ready returns after exactly H cycles.
5. Assert comm_start again mid-transfer.
   - Ignored: no extra SCLK edges, transfer length unchanged.
   - Start and abort together in IDLE: no transfer.
6. Drive rst=0 mid-transfer, asynchronous to sys_clk.
   - ss_out inactive, sclk_out=0 and miso_data=0 immediately.
   - After release, bus_ready rises after H cycles and a clean 16'h4ac5 transfer follows.
